// File: rtl/frame_reader_if.sv
// Bus bundle for frame_reader: frame control, Avalon-MM burst read master
// and 24-bit Avalon-ST video source.
`timescale 1ns/1ps
interface frame_reader_if #(
   parameter int DATA_WIDTH        = 32,
   parameter int ADD_WIDTH         = 32,
   parameter int BURST_WIDTH_R     = 6,
   parameter int BYTE_ENABLE_WIDTH = 4
);
   // frame control
   logic                         start;
   logic [ADD_WIDTH-1:0]         base_add;
   logic [DATA_WIDTH-1:0]        n_words;
   logic                         busy;
   logic                         endf;
   // Avalon-MM read master
   logic [ADD_WIDTH-1:0]         ram_r_address;
   logic                         ram_r_waitrequest;
   logic                         ram_r_readdatavalid;
   logic [BYTE_ENABLE_WIDTH-1:0] ram_r_byteenable;
   logic                         ram_r_read;
   logic [DATA_WIDTH-1:0]        ram_r_readdata;
   logic [BURST_WIDTH_R-1:0]     ram_r_burstcount;
   // Avalon-ST source
   logic [23:0]                  dout_data;
   logic                         dout_valid;
   logic                         dout_ready;
   logic                         dout_sop;
   logic                         dout_eop;

   modport master (
      input  start, base_add, n_words,
      output busy, endf,
      output ram_r_address, ram_r_byteenable, ram_r_read, ram_r_burstcount,
      input  ram_r_waitrequest, ram_r_readdatavalid, ram_r_readdata,
      output dout_data, dout_valid, dout_sop, dout_eop,
      input  dout_ready
   );

   modport slave (
      output start, base_add, n_words,
      input  busy, endf,
      input  ram_r_address, ram_r_byteenable, ram_r_read, ram_r_burstcount,
      output ram_r_waitrequest, ram_r_readdatavalid, ram_r_readdata,
      input  dout_data, dout_valid, dout_sop, dout_eop,
      output dout_ready
   );
endinterface

// File: rtl/frame_reader.sv
// frame_reader: replays one stored frame from RAM as an Avalon-ST video
// packet (header beat + one beat per pixel). Burst reads fill a prefetch
// FIFO; bursts are only issued when the FIFO is guaranteed to have room
// for every word already requested plus the new burst.
`timescale 1ns/1ps
module frame_reader #(
   parameter int DATA_WIDTH        = 32,
   parameter int ADD_WIDTH         = 32,
   parameter int BURST_WIDTH_R     = 6,
   parameter int BYTE_ENABLE_WIDTH = 4,
   parameter int FIFO_DEPTH_LOG2   = 8
) (
   input  logic          clk,
   input  logic          rst,
   frame_reader_if.master bus
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CW    = FIFO_DEPTH_LOG2 + 2;   // room for used + outstanding + burst
   localparam int MAXB  = 1 << (BURST_WIDTH_R - 1);

   typedef enum logic [1:0] {R_IDLE, R_REQ, R_DONE} r_state_t;
   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PIX, S_END} s_state_t;

   r_state_t r_state, r_next;
   s_state_t s_state, s_next;

   logic [ADD_WIDTH-1:0]       addr;
   logic [DATA_WIDTH-1:0]      rd_left;
   logic [DATA_WIDTH-1:0]      out_left;
   logic [CW-1:0]              outstanding;
   logic                       rd_req;
   logic [BURST_WIDTH_R-1:0]   req_len;

   logic [23:0]                fifo_mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]              fifo_used;

   logic                       busy, start_acc, frame_end;
   logic                       push, pop, fifo_empty, accept, issue, credit_ok;
   logic [BURST_WIDTH_R-1:0]   blen;
   logic                       unused_readdata;

   // Largest legal burst for the words still to be requested.
   function automatic logic [BURST_WIDTH_R-1:0] burst_len(input logic [DATA_WIDTH-1:0] left);
      if (left >= DATA_WIDTH'(MAXB))
         burst_len = BURST_WIDTH_R'(MAXB);
      else
         burst_len = left[BURST_WIDTH_R-1:0];
   endfunction

   // The busy window excludes S_END so a new start may chain directly onto endf.
   assign busy       = (s_state == S_HDR) || (s_state == S_PIX);
   assign start_acc  = bus.start && !busy;
   assign frame_end  = (s_state == S_END);
   assign accept     = rd_req && !bus.ram_r_waitrequest;
   assign push       = bus.ram_r_readdatavalid && (r_state != R_IDLE);
   assign fifo_empty = (fifo_used == '0);
   assign pop        = (s_state == S_PIX) && !fifo_empty && bus.dout_ready;
   assign blen       = burst_len(rd_left);
   assign credit_ok  = (fifo_used + outstanding + CW'(blen)) <= CW'(DEPTH);

   assign bus.busy             = busy;
   assign bus.endf             = frame_end;
   assign bus.ram_r_read       = rd_req;
   assign bus.ram_r_address    = addr;
   assign bus.ram_r_burstcount = req_len;
   assign bus.ram_r_byteenable = {BYTE_ENABLE_WIDTH{1'b1}};

   // Only the pixel byte lanes are stored; the padding byte is dropped.
   assign unused_readdata = &{1'b0, bus.ram_r_readdata[DATA_WIDTH-1:24]};

   // State registers for both FSMs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= R_IDLE;
         s_state <= S_IDLE;
      end else begin
         r_state <= r_next;
         s_state <= s_next;
      end
   end

   // Read FSM: one burst request at a time, gated by FIFO credit.
   always_comb begin
      r_next = r_state;
      issue  = 1'b0;
      case (r_state)
         R_IDLE: if (start_acc) r_next = R_REQ;
         R_REQ: begin
            issue = !rd_req && (rd_left != '0) && credit_ok;
            if (!rd_req && (rd_left == '0)) r_next = R_DONE;
         end
         R_DONE: if (frame_end) r_next = start_acc ? R_REQ : R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // Stream FSM: header beat, then pixels from the FIFO head, then endf.
   always_comb begin
      s_next         = s_state;
      bus.dout_valid = 1'b0;
      bus.dout_data  = '0;
      bus.dout_sop   = 1'b0;
      bus.dout_eop   = 1'b0;
      case (s_state)
         S_IDLE: if (start_acc) s_next = S_HDR;
         S_HDR: begin
            bus.dout_valid = 1'b1;
            bus.dout_sop   = 1'b1;
            bus.dout_eop   = (out_left == '0);
            if (bus.dout_ready) s_next = (out_left == '0) ? S_END : S_PIX;
         end
         S_PIX: begin
            bus.dout_valid = !fifo_empty;
            bus.dout_data  = fifo_empty ? 24'h000000 : fifo_mem[rd_ptr];
            bus.dout_eop   = !fifo_empty && (out_left == DATA_WIDTH'(1));
            if (pop && (out_left == DATA_WIDTH'(1))) s_next = S_END;
         end
         S_END: s_next = start_acc ? S_HDR : S_IDLE;
         default: s_next = S_IDLE;
      endcase
   end

   // Frame counters, burst request register and credit accounting.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr        <= '0;
         rd_left     <= '0;
         out_left    <= '0;
         outstanding <= '0;
         rd_req      <= 1'b0;
         req_len     <= '0;
      end else begin
         outstanding <= outstanding + (accept ? CW'(req_len) : CW'(0)) - CW'(push);
         if (start_acc) begin
            addr     <= bus.base_add;
            rd_left  <= bus.n_words;
            out_left <= bus.n_words;
         end else begin
            if (issue) begin
               rd_req  <= 1'b1;
               req_len <= blen;
            end
            if (accept) begin
               rd_req  <= 1'b0;
               addr    <= addr + ADD_WIDTH'({req_len, 2'b00});
               rd_left <= rd_left - DATA_WIDTH'(req_len);
            end
            if (pop) out_left <= out_left - DATA_WIDTH'(1);
         end
      end
   end

   // FIFO pointers and fill level.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_used <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fifo_used <= fifo_used + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage (data only, no reset).
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.ram_r_readdata[23:0];
   end

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: behavioural burst RAM slave, stream sink
// with programmable backpressure, and per-scenario checking tasks.
`timescale 1ns/1ps
module tb_frame_reader;

   logic clk;
   logic rst;
   frame_reader_if bus ();

   frame_reader dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;

   // sink / slave configuration
   int rdy_mode    = 0;   // 0: always ready, 1: ready one cycle in four
   int wait_cycles = 0;   // waitrequest cycles per burst

   // captured traffic
   logic [23:0] beat_data [$];
   logic        beat_sop  [$];
   logic        beat_eop  [$];
   logic [31:0] bq_addr   [$];
   int          bq_len    [$];
   logic [31:0] rdv_q     [$];
   int endf_cnt = 0, hold_err = 0, wr_err = 0;
   int accepted = 0, popped = 0, max_credit = 0, cyc = 0;
   int stall_cnt = 0;
   logic        hold_pend = 1'b0;
   logic [25:0] hold_val;
   logic [31:0] st_addr;
   logic [5:0]  st_len;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      logic [31:0] w;
      w = a >> 2;
      return {8'hA5, w[7:0] ^ 8'h3C, w[15:8] + 8'h40, w[7:0]};
   endfunction

   function automatic logic [23:0] exp_pix(input logic [31:0] base, input int i);
      logic [31:0] w;
      w = ram_word(base + 32'(i) * 32'd4);
      return w[23:0];
   endfunction

   // Sink and RAM slave; drives for the next rising edge, observes mid-cycle.
   always @(negedge clk) begin
      cyc++;
      bus.dout_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
      if (hold_pend && (!bus.dout_valid ||
          {bus.dout_sop, bus.dout_eop, bus.dout_data} != hold_val))
         hold_err++;
      hold_pend = bus.dout_valid && !bus.dout_ready;
      hold_val  = {bus.dout_sop, bus.dout_eop, bus.dout_data};
      if (bus.dout_valid && bus.dout_ready) begin
         beat_data.push_back(bus.dout_data);
         beat_sop.push_back(bus.dout_sop);
         beat_eop.push_back(bus.dout_eop);
         if (!bus.dout_sop) popped++;
      end
      if (bus.endf) endf_cnt++;
      if (rdv_q.size() > 0) begin
         bus.ram_r_readdatavalid = 1'b1;
         bus.ram_r_readdata      = ram_word(rdv_q.pop_front());
      end else begin
         bus.ram_r_readdatavalid = 1'b0;
         bus.ram_r_readdata      = 32'hDEADBEEF;
      end
      if (bus.ram_r_read) begin
         if (stall_cnt == 0) begin
            st_addr = bus.ram_r_address;
            st_len  = bus.ram_r_burstcount;
         end else if (bus.ram_r_address != st_addr || bus.ram_r_burstcount != st_len)
            wr_err++;
         if (stall_cnt < wait_cycles) begin
            bus.ram_r_waitrequest = 1'b1;
            stall_cnt++;
         end else begin
            bus.ram_r_waitrequest = 1'b0;
            stall_cnt = 0;
            bq_addr.push_back(bus.ram_r_address);
            bq_len.push_back(int'(bus.ram_r_burstcount));
            for (int k = 0; k < int'(bus.ram_r_burstcount); k++)
               rdv_q.push_back(bus.ram_r_address + 32'(k) * 32'd4);
            accepted += int'(bus.ram_r_burstcount);
         end
      end else begin
         if (stall_cnt != 0) wr_err++;
         stall_cnt = 0;
         bus.ram_r_waitrequest = 1'b0;
      end
      if (accepted - popped > max_credit) max_credit = accepted - popped;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_log();
      beat_data.delete(); beat_sop.delete(); beat_eop.delete();
      bq_addr.delete(); bq_len.delete();
      hold_err = 0; wr_err = 0; accepted = 0; popped = 0; max_credit = 0;
   endtask

   task automatic pulse_start(input logic [31:0] base, input logic [31:0] n);
      bus.base_add = base;
      bus.n_words  = n;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
   endtask

   task automatic wait_endf(input int prev, input string name);
      int t;
      t = 0;
      while (endf_cnt == prev && t < 4000) begin
         tick();
         t++;
      end
      if (endf_cnt == prev) begin
         n_cmp++; n_err++;
         $display("FAIL %s timeout: endf not seen within %0d cycles", name, t);
      end
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if ({bus.busy, bus.endf, bus.ram_r_read, bus.dout_valid, bus.dout_sop, bus.dout_eop} !== 6'b0) begin
         n_err++; $display("FAIL reset_ctrl: got %b required 000000",
            {bus.busy, bus.endf, bus.ram_r_read, bus.dout_valid, bus.dout_sop, bus.dout_eop});
      end
      n_cmp++;
      if ({bus.ram_r_address, bus.ram_r_burstcount, bus.dout_data} !== 62'd0) begin
         n_err++; $display("FAIL reset_data: addr %h burst %0d data %h required all 0",
            bus.ram_r_address, bus.ram_r_burstcount, bus.dout_data);
      end
      n_cmp++;
      if (bus.ram_r_byteenable !== 4'hF) begin
         n_err++; $display("FAIL reset_byteenable: got %h required f", bus.ram_r_byteenable);
      end
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_basic();
      int prev;
      clear_log();
      prev = endf_cnt;
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %b required 0", bus.busy); end
      pulse_start(32'h1000, 32'd40);
      n_cmp++;
      if ({bus.busy, bus.dout_valid, bus.dout_sop} !== 3'b111) begin
         n_err++; $display("FAIL basic_header_timing: busy/valid/sop %b required 111",
            {bus.busy, bus.dout_valid, bus.dout_sop});
      end
      wait_endf(prev, "basic");
      n_cmp++;
      if (bq_addr.size() !== 2) begin n_err++; $display("FAIL basic_nbursts: got %0d required 2", bq_addr.size()); end
      else begin
         n_cmp++;
         if (bq_addr[0] !== 32'h1000 || bq_len[0] !== 32) begin
            n_err++; $display("FAIL basic_burst0: got (%h,%0d) required (1000,32)", bq_addr[0], bq_len[0]);
         end
         n_cmp++;
         if (bq_addr[1] !== 32'h1080 || bq_len[1] !== 8) begin
            n_err++; $display("FAIL basic_burst1: got (%h,%0d) required (1080,8)", bq_addr[1], bq_len[1]);
         end
      end
      n_cmp++;
      if (beat_data.size() !== 41) begin n_err++; $display("FAIL basic_nbeats: got %0d required 41", beat_data.size()); end
      else begin
         n_cmp++;
         if ({beat_sop[0], beat_eop[0], beat_data[0]} !== {2'b10, 24'h0}) begin
            n_err++; $display("FAIL basic_header: sop %b eop %b data %h required 1 0 000000",
               beat_sop[0], beat_eop[0], beat_data[0]);
         end
         for (int i = 1; i <= 40; i++) begin
            n_cmp++;
            if ({beat_sop[i], beat_eop[i], beat_data[i]} !== {1'b0, (i == 40), exp_pix(32'h1000, i - 1)}) begin
               n_err++; $display("FAIL basic_pix%0d: sop %b eop %b data %h required 0 %b %h", i,
                  beat_sop[i], beat_eop[i], beat_data[i], (i == 40), exp_pix(32'h1000, i - 1));
            end
         end
      end
      n_cmp++;
      if (endf_cnt - prev !== 1 || bus.busy !== 1'b0) begin
         n_err++; $display("FAIL basic_endf: endf %0d busy %b required 1 0", endf_cnt - prev, bus.busy);
      end
   endtask

   task automatic test_backpressure();
      int prev;
      clear_log();
      rdy_mode = 1;
      prev = endf_cnt;
      pulse_start(32'h0002_0000, 32'd300);
      wait_endf(prev, "backpressure");
      rdy_mode = 0;
      n_cmp++;
      if (max_credit > 256) begin n_err++; $display("FAIL bp_credit: peak %0d required <= 256", max_credit); end
      n_cmp++;
      if (hold_err !== 0) begin n_err++; $display("FAIL bp_hold: %0d unstable stalled beats required 0", hold_err); end
      n_cmp++;
      if (bq_addr.size() !== 10) begin n_err++; $display("FAIL bp_nbursts: got %0d required 10", bq_addr.size()); end
      else begin
         n_cmp++;
         if (bq_addr[9] !== 32'h0002_0480 || bq_len[9] !== 12) begin
            n_err++; $display("FAIL bp_lastburst: got (%h,%0d) required (20480,12)", bq_addr[9], bq_len[9]);
         end
      end
      n_cmp++;
      if (beat_data.size() !== 301) begin n_err++; $display("FAIL bp_nbeats: got %0d required 301", beat_data.size()); end
      else begin
         for (int i = 1; i <= 300; i++) begin
            n_cmp++;
            if ({beat_eop[i], beat_data[i]} !== {(i == 300), exp_pix(32'h0002_0000, i - 1)}) begin
               n_err++; $display("FAIL bp_pix%0d: eop %b data %h required %b %h", i, beat_eop[i],
                  beat_data[i], (i == 300), exp_pix(32'h0002_0000, i - 1));
            end
         end
      end
      n_cmp++;
      if (endf_cnt - prev !== 1) begin n_err++; $display("FAIL bp_endf: got %0d required 1", endf_cnt - prev); end
   endtask

   task automatic test_waitrequest();
      int prev;
      clear_log();
      wait_cycles = 5;
      prev = endf_cnt;
      pulse_start(32'h4000, 32'd64);
      wait_endf(prev, "waitreq");
      wait_cycles = 0;
      n_cmp++;
      if (wr_err !== 0) begin n_err++; $display("FAIL wr_stable: %0d request changes while stalled required 0", wr_err); end
      n_cmp++;
      if (bq_addr.size() !== 2) begin n_err++; $display("FAIL wr_nbursts: got %0d required 2", bq_addr.size()); end
      else begin
         n_cmp++;
         if (bq_addr[0] !== 32'h4000 || bq_len[0] !== 32 || bq_addr[1] !== 32'h4080 || bq_len[1] !== 32) begin
            n_err++; $display("FAIL wr_bursts: got (%h,%0d)(%h,%0d) required (4000,32)(4080,32)",
               bq_addr[0], bq_len[0], bq_addr[1], bq_len[1]);
         end
      end
      n_cmp++;
      if (beat_data.size() !== 65) begin n_err++; $display("FAIL wr_nbeats: got %0d required 65", beat_data.size()); end
      else begin
         for (int i = 1; i <= 64; i++) begin
            n_cmp++;
            if (beat_data[i] !== exp_pix(32'h4000, i - 1)) begin
               n_err++; $display("FAIL wr_pix%0d: got %h required %h", i, beat_data[i], exp_pix(32'h4000, i - 1));
            end
         end
      end
   endtask

   task automatic test_empty();
      int prev;
      clear_log();
      prev = endf_cnt;
      pulse_start(32'h3000, 32'd0);
      wait_endf(prev, "empty");
      n_cmp++;
      if (bq_addr.size() !== 0) begin n_err++; $display("FAIL empty_reads: got %0d bursts required 0", bq_addr.size()); end
      n_cmp++;
      if (beat_data.size() !== 1) begin n_err++; $display("FAIL empty_nbeats: got %0d required 1", beat_data.size()); end
      else begin
         n_cmp++;
         if ({beat_sop[0], beat_eop[0], beat_data[0]} !== {2'b11, 24'h0}) begin
            n_err++; $display("FAIL empty_beat: sop %b eop %b data %h required 1 1 000000",
               beat_sop[0], beat_eop[0], beat_data[0]);
         end
      end
      n_cmp++;
      if (endf_cnt - prev !== 1 || bus.busy !== 1'b0) begin
         n_err++; $display("FAIL empty_endf: endf %0d busy %b required 1 0", endf_cnt - prev, bus.busy);
      end
   endtask

   task automatic test_reset_mid();
      int prev, t;
      clear_log();
      prev = endf_cnt;
      pulse_start(32'h8000, 32'd100);
      t = 0;
      while (beat_data.size() < 11 && t < 500) begin tick(); t++; end
      n_cmp++;
      if (beat_data.size() < 11) begin n_err++; $display("FAIL rst_mid_progress: got %0d beats required 11", beat_data.size()); end
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({bus.busy, bus.endf, bus.ram_r_read, bus.dout_valid, bus.dout_sop, bus.dout_eop,
           bus.ram_r_address, bus.ram_r_burstcount, bus.dout_data} !== 68'd0) begin
         n_err++; $display("FAIL rst_mid_outputs: busy %b read %b valid %b addr %h data %h required all 0",
            bus.busy, bus.ram_r_read, bus.dout_valid, bus.ram_r_address, bus.dout_data);
      end
      rst = 1'b0;
      clear_log();
      t = 0;
      while (rdv_q.size() > 0 && t < 500) begin tick(); t++; end
      repeat (4) tick();
      n_cmp++;
      if (endf_cnt !== prev || beat_data.size() !== 0) begin
         n_err++; $display("FAIL rst_mid_quiet: endf %0d beats %0d required 0 0", endf_cnt - prev, beat_data.size());
      end
      clear_log();
      pulse_start(32'h9000, 32'd5);
      wait_endf(prev, "rst_restart");
      n_cmp++;
      if (beat_data.size() !== 6) begin n_err++; $display("FAIL rst_restart_nbeats: got %0d required 6", beat_data.size()); end
      else begin
         for (int i = 1; i <= 5; i++) begin
            n_cmp++;
            if ({beat_eop[i], beat_data[i]} !== {(i == 5), exp_pix(32'h9000, i - 1)}) begin
               n_err++; $display("FAIL rst_restart_pix%0d: eop %b data %h required %b %h", i, beat_eop[i],
                  beat_data[i], (i == 5), exp_pix(32'h9000, i - 1));
            end
         end
      end
      n_cmp++;
      if (endf_cnt - prev !== 1) begin n_err++; $display("FAIL rst_restart_endf: got %0d required 1", endf_cnt - prev); end
   endtask

   task automatic test_start_busy();
      int prev;
      clear_log();
      prev = endf_cnt;
      pulse_start(32'hA000, 32'd50);
      repeat (15) tick();
      pulse_start(32'hF000, 32'd7);
      wait_endf(prev, "start_busy");
      repeat (20) tick();
      n_cmp++;
      if (endf_cnt - prev !== 1 || bus.busy !== 1'b0) begin
         n_err++; $display("FAIL sb_endf: endf %0d busy %b required 1 0", endf_cnt - prev, bus.busy);
      end
      n_cmp++;
      if (bq_addr.size() !== 2) begin n_err++; $display("FAIL sb_nbursts: got %0d required 2", bq_addr.size()); end
      else begin
         n_cmp++;
         if (bq_addr[0] !== 32'hA000 || bq_len[0] !== 32 || bq_addr[1] !== 32'hA080 || bq_len[1] !== 18) begin
            n_err++; $display("FAIL sb_bursts: got (%h,%0d)(%h,%0d) required (a000,32)(a080,18)",
               bq_addr[0], bq_len[0], bq_addr[1], bq_len[1]);
         end
      end
      n_cmp++;
      if (beat_data.size() !== 51) begin n_err++; $display("FAIL sb_nbeats: got %0d required 51", beat_data.size()); end
      else begin
         for (int i = 1; i <= 50; i++) begin
            n_cmp++;
            if ({beat_eop[i], beat_data[i]} !== {(i == 50), exp_pix(32'hA000, i - 1)}) begin
               n_err++; $display("FAIL sb_pix%0d: eop %b data %h required %b %h", i, beat_eop[i],
                  beat_data[i], (i == 50), exp_pix(32'hA000, i - 1));
            end
         end
      end
   endtask

   initial begin
      rst                     = 1'b1;
      bus.start               = 1'b0;
      bus.base_add            = '0;
      bus.n_words             = '0;
      bus.ram_r_waitrequest   = 1'b0;
      bus.ram_r_readdatavalid = 1'b0;
      bus.ram_r_readdata      = '0;
      bus.dout_ready          = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_waitrequest();
      test_empty();
      test_reset_mid();
      test_start_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
